// File: rtl/riscv_defines.sv
// Shared definitions for the branch target buffer: default geometry,
// entry layout and the sweep FSM encoding.
package riscv_defines;

    localparam int BTB_SETS    = 16;
    localparam int BTB_WAYS    = 2;
    localparam int BTB_TAG_MAX = 30;

    // Tag is right-justified; bits above the instance's TAG_W stay zero.
    typedef struct packed {
        logic                   valid;
        logic [BTB_TAG_MAX-1:0] tag;
        logic [31:0]            target;
    } btb_sa_entry_t;

    typedef enum logic {
        BTB_IDLE  = 1'b0,
        BTB_CLEAR = 1'b1
    } btb_state_t;

    function automatic int btb_way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Victim way choice for a BTB fill: lowest invalid way first, otherwise the
// set's round-robin pointer, which advances only when it was used.
module btb_victim_sel
    import riscv_defines::*;
#(
    parameter int SETS  = BTB_SETS,
    parameter int WAYS  = BTB_WAYS,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = btb_way_w(WAYS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic             advance,
    input  logic             clear,
    input  logic [IDX_W-1:0] clear_idx,
    output logic [WAY_W-1:0] victim,
    output logic             has_invalid
);

    // Pointer storage is established by the sweep, never by reset.
    logic [WAY_W-1:0] ptr_mem [SETS];
    logic [WAY_W-1:0] ptr_cur;
    logic [WAY_W-1:0] inv_way;

    assign ptr_cur = ptr_mem[set_idx];

    always_comb begin
        inv_way     = '0;
        has_invalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) begin
                inv_way     = WAY_W'(w);
                has_invalid = 1'b1;
            end
        end
    end

    assign victim = has_invalid ? inv_way : ptr_cur;

    always_ff @(posedge clk) begin
        if (clear) begin
            ptr_mem[clear_idx] <= '0;
        end else if (advance) begin
            ptr_mem[set_idx] <= (ptr_cur == WAY_W'(WAYS - 1)) ? '0 : ptr_cur + 1'b1;
        end
    end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer with combinational lookup, resolution
// updates one cycle later, and a one-set-per-cycle invalidation sweep.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// BTB_IDLE  | lookups live, resolved branches update the table
// BTB_CLEAR | sweeping set clr_cnt to invalid; busy=1, no hits, no updates
module btb_set_assoc
    import riscv_defines::*;
#(
    parameter int SETS     = BTB_SETS,
    parameter int WAYS     = BTB_WAYS,
    parameter int TAG_W    = 30 - $clog2(SETS),
    parameter int EVICT_NT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    output logic        busy,
    input  logic [31:0] pc_f,
    output logic        btb_hit,
    output logic [31:0] pred_target,
    input  logic [31:0] pc_m,
    input  logic        cflow_valid,
    input  logic        cflow_taken,
    input  logic [31:0] cflow_target
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = btb_way_w(WAYS);

    btb_state_t       state, state_nx;
    logic [IDX_W-1:0] clr_cnt, clr_cnt_nx;
    logic [IDX_W-1:0] clr_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BTB_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        case (state)
            BTB_IDLE: begin
                if (flush) begin
                    state_nx   = BTB_CLEAR;
                    clr_cnt_nx = '0;
                end
            end
            BTB_CLEAR: begin
                if (flush) begin
                    clr_cnt_nx = '0;
                end else if (clr_cnt == IDX_W'(SETS - 1)) begin
                    state_nx   = BTB_IDLE;
                    clr_cnt_nx = '0;
                end else begin
                    clr_cnt_nx = clr_cnt + 1'b1;
                end
            end
            default: begin
                state_nx   = BTB_CLEAR;
                clr_cnt_nx = '0;
            end
        endcase
    end

    // rst forces the sweep outputs combinationally so the first reset cycle is clean.
    assign busy    = rst | (state == BTB_CLEAR);
    assign clr_idx = rst ? '0 : clr_cnt;

    logic [IDX_W-1:0] idx_f, idx_m;
    logic [TAG_W-1:0] tag_f, tag_m;

    assign idx_f = pc_f[2 +: IDX_W];
    assign idx_m = pc_m[2 +: IDX_W];
    assign tag_f = pc_f[31 -: TAG_W];
    assign tag_m = pc_m[31 -: TAG_W];

    btb_sa_entry_t    rd_f [WAYS];
    btb_sa_entry_t    rd_m [WAYS];
    btb_sa_entry_t    wr_entry;
    logic [IDX_W-1:0] wr_idx;
    logic [WAYS-1:0]  way_we;
    logic [WAYS-1:0]  hit_vec_f, hit_vec_m, valid_m;
    logic [WAYS-1:0]  unused_rd;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_sa_entry_t mem [SETS];

        always_ff @(posedge clk) begin
            if (way_we[w]) begin
                mem[wr_idx] <= wr_entry;
            end
        end

        assign rd_f[w]      = mem[idx_f];
        assign rd_m[w]      = mem[idx_m];
        assign hit_vec_f[w] = rd_f[w].valid && (rd_f[w].tag[TAG_W-1:0] == tag_f);
        assign hit_vec_m[w] = rd_m[w].valid && (rd_m[w].tag[TAG_W-1:0] == tag_m);
        assign valid_m[w]   = rd_m[w].valid;
        assign unused_rd[w] = ^{rd_f[w].tag, rd_m[w].tag, rd_m[w].target};
    end

    logic             any_f, any_m;
    logic [WAY_W-1:0] hit_way_f, hit_way_m;

    always_comb begin
        any_f     = 1'b0;
        any_m     = 1'b0;
        hit_way_f = '0;
        hit_way_m = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec_f[w]) begin
                any_f     = 1'b1;
                hit_way_f = WAY_W'(w);
            end
            if (hit_vec_m[w]) begin
                any_m     = 1'b1;
                hit_way_m = WAY_W'(w);
            end
        end
    end

    assign btb_hit     = any_f & ~busy;
    assign pred_target = btb_hit ? rd_f[hit_way_f].target : 32'h0;

    logic             upd_ok;
    logic             vic_advance;
    logic             vic_has_inv;
    logic [WAY_W-1:0] vic_way;

    assign upd_ok = cflow_valid & ~busy;

    btb_victim_sel #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_victim (
        .clk         (clk),
        .set_idx     (idx_m),
        .valid_vec   (valid_m),
        .advance     (vic_advance),
        .clear       (busy),
        .clear_idx   (clr_idx),
        .victim      (vic_way),
        .has_invalid (vic_has_inv)
    );

    always_comb begin
        way_we                   = '0;
        wr_idx                   = idx_m;
        vic_advance              = 1'b0;
        wr_entry                 = '0;
        wr_entry.valid           = 1'b1;
        wr_entry.tag[TAG_W-1:0]  = tag_m;
        wr_entry.target          = cflow_target;
        if (busy) begin
            way_we   = '1;
            wr_idx   = clr_idx;
            wr_entry = '0;
        end else if (upd_ok) begin
            if (any_m) begin
                if (cflow_taken) begin
                    way_we[hit_way_m] = 1'b1;
                end else if (EVICT_NT != 0) begin
                    way_we[hit_way_m] = 1'b1;
                    wr_entry.valid    = 1'b0;
                end
            end else if (cflow_taken) begin
                way_we[vic_way] = 1'b1;
                vic_advance     = ~vic_has_inv;
            end
        end
    end

    logic unused_pc;
    assign unused_pc = ^{pc_f, pc_m, unused_rd};

endmodule
